// File: rtl/reset_sequencer.sv
// Power-up reset sequencer: waits for a stable PLL lock, then releases reset domains one at a time,
// waiting for each domain's ack plus a settling delay before moving on; an ack timeout latches FAULT.
module reset_sequencer #(
    parameter int NUM_STAGES  = 4,
    parameter int LOCK_STABLE = 256,
    parameter int STAGE_DLY   = 1000,
    parameter int ACK_TIMEOUT = 65535,
    parameter int CNT_W       = 24
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  pll_locked,
    input  logic [NUM_STAGES-1:0] stage_ack,
    input  logic                  sw_restart,
    output logic [NUM_STAGES-1:0] stage_rst,
    output logic                  all_ready,
    output logic                  fault,
    output logic [2:0]            fault_stage
);

    localparam logic [2:0] S_WAIT_LOCK   = 3'd0;
    localparam logic [2:0] S_LOCK_STABLE = 3'd1;
    localparam logic [2:0] S_WAIT_ACK    = 3'd2;
    localparam logic [2:0] S_DELAY       = 3'd3;
    localparam logic [2:0] S_DONE        = 3'd4;
    localparam logic [2:0] S_FAULT       = 3'd5;

    // Each state ends when the shared counter reaches its own limit minus one, so it never wraps.
    localparam logic [CNT_W-1:0] LOCK_LIM = CNT_W'(LOCK_STABLE - 1);
    localparam logic [CNT_W-1:0] DLY_LIM  = CNT_W'(STAGE_DLY - 1);
    localparam logic [CNT_W-1:0] ACK_LIM  = CNT_W'(ACK_TIMEOUT - 1);
    localparam logic [2:0]       LAST_IDX = 3'(NUM_STAGES - 1);

    logic [2:0]       state;
    logic [2:0]       idx;
    logic [CNT_W-1:0] cnt;
    logic             ack_cur;
    logic             lock_lost;
    logic             restart_req;

    // Stages above k remain held in reset; k and everything below are released.
    function automatic logic [NUM_STAGES-1:0] held_mask(input logic [2:0] k);
        logic [NUM_STAGES-1:0] m;
        for (int i = 0; i < NUM_STAGES; i++) begin
            m[i] = (3'(i) > k);
        end
        return m;
    endfunction

    always_comb begin
        ack_cur = 1'b0;
        for (int i = 0; i < NUM_STAGES; i++) begin
            if (idx == 3'(i)) begin
                ack_cur = stage_ack[i];
            end
        end
    end

    assign lock_lost   = (state != S_WAIT_LOCK) && !pll_locked;
    assign restart_req = ((state == S_DONE) || (state == S_FAULT)) && sw_restart;

    always_ff @(posedge clk) begin
        if (rst) begin
            state       <= S_WAIT_LOCK;
            idx         <= 3'd0;
            cnt         <= '0;
            stage_rst   <= '1;
            all_ready   <= 1'b0;
            fault       <= 1'b0;
            fault_stage <= 3'd0;
        end else if (lock_lost || restart_req) begin
            // Lock loss outranks a software restart, but both land in the same place.
            state     <= S_WAIT_LOCK;
            idx       <= 3'd0;
            cnt       <= '0;
            stage_rst <= '1;
            all_ready <= 1'b0;
            fault     <= 1'b0;
        end else begin
            case (state)
                S_WAIT_LOCK: begin
                    if (pll_locked) begin
                        state <= S_LOCK_STABLE;
                        cnt   <= '0;
                    end
                end
                S_LOCK_STABLE: begin
                    if (cnt == LOCK_LIM) begin
                        state     <= S_WAIT_ACK;
                        idx       <= 3'd0;
                        cnt       <= '0;
                        stage_rst <= held_mask(3'd0);
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
                S_WAIT_ACK: begin
                    // The ack is checked first so it wins over a coincident timeout.
                    if (ack_cur) begin
                        state <= S_DELAY;
                        cnt   <= '0;
                    end else if (cnt == ACK_LIM) begin
                        state       <= S_FAULT;
                        cnt         <= '0;
                        stage_rst   <= '1;
                        fault       <= 1'b1;
                        fault_stage <= idx;
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
                S_DELAY: begin
                    if (cnt == DLY_LIM) begin
                        cnt <= '0;
                        if (idx == LAST_IDX) begin
                            state     <= S_DONE;
                            stage_rst <= '0;
                            all_ready <= 1'b1;
                        end else begin
                            state     <= S_WAIT_ACK;
                            idx       <= idx + 3'd1;
                            stage_rst <= held_mask(idx + 3'd1);
                        end
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
                S_DONE: begin
                    stage_rst <= '0;
                    all_ready <= 1'b1;
                end
                S_FAULT: begin
                    stage_rst <= '1;
                    fault     <= 1'b1;
                end
                default: begin
                    state     <= S_WAIT_LOCK;
                    idx       <= 3'd0;
                    cnt       <= '0;
                    stage_rst <= '1;
                    all_ready <= 1'b0;
                    fault     <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: doc/reset_sequencer.md
RESET_SEQUENCER -- requirements
Module: reset_sequencer

Interface
REQ-001 SHALL have parameter NUM_STAGES, default 4, number of sequenced reset domains, legal range 1..8.
REQ-002 SHALL have parameter LOCK_STABLE, default 256, cycles pll_locked must stay high before the first release, minimum 1.
REQ-003 SHALL have parameter STAGE_DLY, default 1000, cycles between a stage ack and the next stage release, minimum 1.
REQ-004 SHALL have parameter ACK_TIMEOUT, default 65535, cycles allowed for a stage ack, minimum 1.
REQ-005 SHALL have parameter CNT_W, default 24, width of the shared cycle counter; every count parameter SHALL fit in CNT_W bits.
REQ-006 clk  input  1  single clock; all logic on its rising edge.
REQ-007 rst  input  1  reset, synchronous, active-high.
REQ-008 pll_locked  input  1  clock-source lock, synchronous to clk.
REQ-009 stage_ack  input  NUM_STAGES  per-stage "out of reset" level, synchronous to clk.
REQ-010 sw_restart  input  1  single-cycle restart request.
REQ-011 stage_rst  output  NUM_STAGES  per-stage reset, active-high, registered.
REQ-012 all_ready  output  1  high only in DONE, registered.
REQ-013 fault  output  1  high only in FAULT, registered.
REQ-014 fault_stage  output  3  index of the stage that timed out, registered.

Function
REQ-015 FSM states SHALL be WAIT_LOCK, LOCK_STABLE, WAIT_ACK, DELAY, DONE and FAULT, with stage index idx starting at 0.
REQ-016 WAIT_LOCK SHALL go to LOCK_STABLE with counter=0 on the edge sampling pll_locked=1.
REQ-017 LOCK_STABLE SHALL last exactly LOCK_STABLE cycles, then go to WAIT_ACK with idx=0.
REQ-018 On the edge entering WAIT_ACK, stage_rst[idx] SHALL go 0; stages below idx stay 0 and stages above idx stay 1.
REQ-019 WAIT_ACK SHALL go to DELAY with counter=0 on the edge sampling stage_ack[idx]=1; stage_ack is ignored in all other states.
REQ-020 WAIT_ACK SHALL go to FAULT after ACK_TIMEOUT cycles without an ack; when an ack and the timeout coincide on the same edge, the ack wins.
REQ-021 DELAY SHALL last exactly STAGE_DLY cycles, then go to DONE if idx==NUM_STAGES-1, else increment idx and re-enter WAIT_ACK.
REQ-022 DONE SHALL hold all stage_rst=0 and all_ready=1.
REQ-023 Entering FAULT SHALL set all stage_rst=1, fault=1 and fault_stage=idx; FAULT SHALL persist until sw_restart or rst.
REQ-024 pll_locked=0 sampled in any state other than WAIT_LOCK SHALL, on that edge, set all stage_rst=1, all_ready=0, fault=0, counter=0 and idx=0, and go to WAIT_LOCK.
REQ-025 sw_restart SHALL act as REQ-024 only in DONE or FAULT; in all other states it SHALL be ignored.
REQ-026 Priority on any edge SHALL be rst > lock loss > sw_restart > normal transition.
REQ-027 The counter SHALL never wrap; each state compares it against its own limit minus 1, and it SHALL clear on every state change.

Reset
REQ-028 On an edge sampling rst=1, the block SHALL set state=WAIT_LOCK, idx=0, counter=0, stage_rst=all ones, all_ready=0, fault=0 and fault_stage=0.
REQ-029 rst SHALL have no effect without a clk edge, and SHALL apply from any state including mid-sequence.

Verification
Bench parameters: NUM_STAGES=3, LOCK_STABLE=4, STAGE_DLY=5, ACK_TIMEOUT=10. Edge 1 is the first edge after rst is released, with pll_locked=1.
REQ-030 Nominal, stage_ack tied to ~stage_rst -> stage_rst[0] falls at edge 5, [1] at edge 11, [2] at edge 17; all_ready=1 from edge 23.
REQ-031 stage_ack[1] held 0 -> WAIT_ACK entered at edge 11; at edge 21 fault=1, fault_stage=1, stage_rst=3'b111; state holds for 50 further cycles.
REQ-032 pll_locked dropped in DELAY after stage 1 -> next edge stage_rst=3'b111 and all_ready=0; relocking reproduces REQ-030 timing relative to the new lock edge.
REQ-033 sw_restart pulsed in WAIT_ACK -> ignored; pulsed in DONE or FAULT -> stage_rst=3'b111 next edge, then the sequence restarts.
REQ-034 stage_ack[0] rising on the exact timeout edge (10th WAIT_ACK cycle) -> DELAY entered, fault stays 0.
REQ-035 rst asserted at edge 14 -> at edge 14 all outputs take their REQ-028 values; rst held low with no clock -> outputs unchanged.
